pu_msp430_per_arbiter: RTL and testbench



---
 rtl/pu_msp430_per_pkg.sv | 23 ++
 rtl/pu_msp430_per_arb_core.sv | 77 +++++++
 rtl/pu_msp430_per_arbiter.sv | 111 +++++++++++
 tb/tb_pu_msp430_per_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pu_msp430_per_pkg.sv
// Shared types for the peripheral-bus arbiter: bus widths, request bundle and master tag.
package pu_msp430_per_pkg;

  localparam int PER_AW  = 14;
  localparam int PER_DW  = 16;
  localparam int PER_WEW = 2;

  typedef struct packed {
    logic [PER_AW-1:0]  addr;
    logic [PER_DW-1:0]  din;
    logic [PER_WEW-1:0] we;
  } per_req_t;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_DMA = 1'b1
  } per_mst_e;

  function automatic logic is_read(input logic [PER_WEW-1:0] we);
    return (we == {PER_WEW{1'b0}});
  endfunction

endpackage

// File: rtl/pu_msp430_per_arb_core.sv
// Grant logic for two peripheral-bus masters: fixed priority with starvation escape,
// or round-robin when PER_ARB_RR_EN is defined.
module pu_msp430_per_arb_core
  import pu_msp430_per_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WD       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_gnt,
  output logic m1_gnt
);

`ifdef PER_ARB_RR_EN

  // ptr_r names the master preferred on the next contention
  per_mst_e ptr_r;

  // Uncontended requests win outright; contention follows the pointer
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (m0_req && m1_req) begin
      m0_gnt = (ptr_r == MST_CPU);
      m1_gnt = (ptr_r == MST_DMA);
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end
  end

  // After any grant, prefer the other master
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= MST_CPU;
    end else if (m0_gnt) begin
      ptr_r <= MST_DMA;
    end else if (m1_gnt) begin
      ptr_r <= MST_CPU;
    end else begin
      ptr_r <= ptr_r;
    end
  end

`else

  localparam logic [CNT_WD-1:0] LIMIT = CNT_WD'(STARVE_LIMIT);

  logic [CNT_WD-1:0] cnt_r;
  logic              starve_s;

  // Master 0 wins unless master 1 has waited STARVE_LIMIT cycles
  always_comb begin
    starve_s = (cnt_r == LIMIT);
    m1_gnt   = m1_req & (~m0_req | starve_s);
    m0_gnt   = m0_req & ~m1_gnt;
  end

  // Count consecutive denied master-1 cycles, saturating at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_WD{1'b0}};
    end else if (!m1_req || m1_gnt) begin
      cnt_r <= {CNT_WD{1'b0}};
    end else if (!starve_s) begin
      cnt_r <= cnt_r + {{(CNT_WD-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

`endif

endmodule

// File: rtl/pu_msp430_per_arbiter.sv
// Two-master peripheral-bus arbiter: registered per_* request stage and tagged read return.
// Optional round-robin arbitration is selected with the PER_ARB_RR_EN macro.
module pu_msp430_per_arbiter
  import pu_msp430_per_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WD       = 4
) (
  input  logic               mclk,
  input  logic               puc_rst_n,
  input  logic               m0_req,
  input  logic [PER_AW-1:0]  m0_addr,
  input  logic [PER_DW-1:0]  m0_din,
  input  logic [PER_WEW-1:0] m0_we,
  output logic               m0_gnt,
  output logic [PER_DW-1:0]  m0_rdata,
  output logic               m0_rvalid,
  input  logic               m1_req,
  input  logic [PER_AW-1:0]  m1_addr,
  input  logic [PER_DW-1:0]  m1_din,
  input  logic [PER_WEW-1:0] m1_we,
  output logic               m1_gnt,
  output logic [PER_DW-1:0]  m1_rdata,
  output logic               m1_rvalid,
  output logic [PER_AW-1:0]  per_addr,
  output logic [PER_DW-1:0]  per_din,
  output logic [PER_WEW-1:0] per_we,
  output logic               per_en,
  input  logic [PER_DW-1:0]  per_dout
);

  per_req_t sel_req_s;
  per_mst_e sel_mst_s;
  logic     gnt_any_s;
  logic     rd_pend_r;
  per_mst_e rd_tag_r;

  pu_msp430_per_arb_core #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_WD       (CNT_WD)
  ) u_arb_core (
    .clk    (mclk),
    .rst_n  (puc_rst_n),
    .m0_req (m0_req),
    .m1_req (m1_req),
    .m0_gnt (m0_gnt),
    .m1_gnt (m1_gnt)
  );

  // Steer the granted master's request onto the shared bus
  always_comb begin
    gnt_any_s = m0_gnt | m1_gnt;
    if (m1_gnt) begin
      sel_req_s = '{addr: m1_addr, din: m1_din, we: m1_we};
      sel_mst_s = MST_DMA;
    end else begin
      sel_req_s = '{addr: m0_addr, din: m0_din, we: m0_we};
      sel_mst_s = MST_CPU;
    end
  end

  // Request stage; per_addr/per_din hold while idle, per_we drops to zero
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      per_en    <= 1'b0;
      per_we    <= {PER_WEW{1'b0}};
      per_addr  <= {PER_AW{1'b0}};
      per_din   <= {PER_DW{1'b0}};
      rd_pend_r <= 1'b0;
      rd_tag_r  <= MST_CPU;
    end else if (gnt_any_s) begin
      per_en    <= 1'b1;
      per_we    <= sel_req_s.we;
      per_addr  <= sel_req_s.addr;
      per_din   <= sel_req_s.din;
      rd_pend_r <= is_read(sel_req_s.we);
      rd_tag_r  <= sel_mst_s;
    end else begin
      per_en    <= 1'b0;
      per_we    <= {PER_WEW{1'b0}};
      per_addr  <= per_addr;
      per_din   <= per_din;
      rd_pend_r <= 1'b0;
      rd_tag_r  <= rd_tag_r;
    end
  end

  // Read return: per_dout is captured at the end of the per_en cycle
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= {PER_DW{1'b0}};
      m1_rdata  <= {PER_DW{1'b0}};
    end else begin
      m0_rvalid <= rd_pend_r & (rd_tag_r == MST_CPU);
      m1_rvalid <= rd_pend_r & (rd_tag_r == MST_DMA);
      if (rd_pend_r && (rd_tag_r == MST_CPU)) begin
        m0_rdata <= per_dout;
      end else begin
        m0_rdata <= m0_rdata;
      end
      if (rd_pend_r && (rd_tag_r == MST_DMA)) begin
        m1_rdata <= per_dout;
      end else begin
        m1_rdata <= m1_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pu_msp430_per_arbiter.sv
// Scoreboard bench for pu_msp430_per_arbiter; expected bus and read-return
// transactions are queued by the driver and retired by a negedge monitor.
module tb_pu_msp430_per_arbiter;

  logic        mclk = 1'b0;
  logic        puc_rst_n;
  logic        m0_req, m1_req;
  logic [13:0] m0_addr, m1_addr;
  logic [15:0] m0_din, m1_din;
  logic [1:0]  m0_we, m1_we;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [1:0]  per_we;
  logic        per_en;
  logic [15:0] per_dout;

  typedef struct {
    int          due;
    logic [13:0] addr;
    logic [15:0] din;
    logic [1:0]  we;
  } per_exp_t;

  typedef struct {
    int          due;
    bit          mst;
    logic [15:0] data;
  } rd_exp_t;

  per_exp_t per_q[$];
  rd_exp_t  rd_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          push_en  = 1'b1;
  bit          exp_ptr  = 1'b0;
  logic [13:0] last_addr = 14'h0000;
  logic [15:0] last_din  = 16'h0000;
  logic [15:0] last_m0   = 16'h0000;
  logic [15:0] last_m1   = 16'h0000;

  pu_msp430_per_arbiter #(.STARVE_LIMIT(4), .CNT_WD(4)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din), .m0_we(m0_we),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din), .m1_we(m1_we),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .per_addr(per_addr), .per_din(per_din), .per_we(per_we), .per_en(per_en),
    .per_dout(per_dout)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  // Peripheral read data table
  function automatic logic [15:0] rd_val(input logic [13:0] a);
    if (a == 14'h0048) return 16'h1234;
    return {2'b10, a} ^ 16'h0F0F;
  endfunction

  assign per_dout = (per_en && per_we == 2'b00) ? rd_val(per_addr) : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit r0, input logic [13:0] a0, input logic [15:0] d0, input logic [1:0] w0,
                       input bit r1, input logic [13:0] a1, input logic [15:0] d1, input logic [1:0] w1);
    m0_req = r0; m0_addr = a0; m0_din = d0; m0_we = w0;
    m1_req = r1; m1_addr = a1; m1_din = d1; m1_we = w1;
  endtask

  // Check grants at the negedge and queue the expected downstream effects
  task automatic sample(input bit eg0, input bit eg1);
    per_exp_t pe;
    rd_exp_t  re;
    @(negedge mclk);
    check("m0_gnt", 32'(m0_gnt), 32'(eg0));
    check("m1_gnt", 32'(m1_gnt), 32'(eg1));
    if (eg0 || eg1) begin
      exp_ptr = eg0;
      if (push_en) begin
        pe.due  = cyc + 1;
        pe.addr = eg1 ? m1_addr : m0_addr;
        pe.din  = eg1 ? m1_din  : m0_din;
        pe.we   = eg1 ? m1_we   : m0_we;
        per_q.push_back(pe);
        if (pe.we == 2'b00) begin
          re.due  = cyc + 2;
          re.mst  = eg1;
          re.data = rd_val(pe.addr);
          rd_q.push_back(re);
        end
      end
    end
  endtask

  task automatic cycle(input bit r0, input logic [13:0] a0, input logic [15:0] d0, input logic [1:0] w0,
                       input bit r1, input logic [13:0] a1, input logic [15:0] d1, input logic [1:0] w1,
                       input bit eg0, input bit eg1);
    @(posedge mclk); #1;
    drive(r0, a0, d0, w0, r1, a1, d1, w1);
    sample(eg0, eg1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 14'h0000, 16'h0000, 2'b00, 1'b0, 14'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
  endtask

  // Monitor: retire queued expectations whenever the DUT presents bus or read traffic
  always @(negedge mclk) begin
    per_exp_t pe;
    rd_exp_t  re;
    if (!puc_rst_n) begin
      check("rst_per_en", 32'(per_en), 32'd0);
      check("rst_per_we", 32'(per_we), 32'd0);
      check("rst_per_addr", 32'(per_addr), 32'd0);
      check("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
      check("rst_m0_rdata", 32'(m0_rdata), 32'd0);
      check("rst_m1_rdata", 32'(m1_rdata), 32'd0);
      last_addr = 14'h0000; last_din = 16'h0000;
      last_m0 = 16'h0000; last_m1 = 16'h0000;
    end else begin
      if (per_en) begin
        if (per_q.size() == 0) begin
          check("per_en_unexpected", 32'(per_en), 32'd0);
        end else begin
          pe = per_q.pop_front();
          check("per_en_cycle", 32'(cyc), 32'(pe.due));
          check("per_addr", 32'(per_addr), 32'(pe.addr));
          check("per_din", 32'(per_din), 32'(pe.din));
          check("per_we", 32'(per_we), 32'(pe.we));
          last_addr = pe.addr; last_din = pe.din;
        end
      end else begin
        check("idle_per_we", 32'(per_we), 32'd0);
        check("idle_per_addr_hold", 32'(per_addr), 32'(last_addr));
        check("idle_per_din_hold", 32'(per_din), 32'(last_din));
      end
      if (m0_rvalid || m1_rvalid) begin
        if (rd_q.size() == 0) begin
          check("rvalid_unexpected", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        end else begin
          re = rd_q.pop_front();
          check("rvalid_cycle", 32'(cyc), 32'(re.due));
          check("rvalid_route", 32'({m1_rvalid, m0_rvalid}), re.mst ? 32'd2 : 32'd1);
          if (re.mst) begin
            check("m1_rdata", 32'(m1_rdata), 32'(re.data));
            last_m1 = re.data;
          end else begin
            check("m0_rdata", 32'(m0_rdata), 32'(re.data));
            last_m0 = re.data;
          end
        end
      end
      if (!m0_rvalid) check("m0_rdata_hold", 32'(m0_rdata), 32'(last_m0));
      if (!m1_rvalid) check("m1_rdata_hold", 32'(m1_rdata), 32'(last_m1));
    end
  end

  initial begin
    logic [13:0] a0, a1;
    bit          eg1;
    puc_rst_n = 1'b0;
    drive(1'b1, 14'h0050, 16'h0000, 2'b00, 1'b0, 14'h0000, 16'h0000, 2'b00);
    repeat (3) @(posedge mclk);

    // Release reset with m0 already requesting: granted in the first cycle
    @(posedge mclk); #1;
    puc_rst_n = 1'b1;
    sample(1'b1, 1'b0);

    // m0 read 0x0048 -> 0x1234
    cycle(1'b1, 14'h0048, 16'h0000, 2'b00, 1'b0, 14'h0000, 16'h0000, 2'b00, 1'b1, 1'b0);
    // m1 byte write to 0x0049
    cycle(1'b0, 14'h0000, 16'h0000, 2'b00, 1'b1, 14'h0049, 16'hAB00, 2'b10, 1'b0, 1'b1);
    idle(3);

    // Continuous contention, all reads so routing is exercised
    a0 = 14'h0100;
    a1 = 14'h0200;
    for (int i = 0; i < 15; i++) begin
`ifdef PER_ARB_RR_EN
      eg1 = exp_ptr;
`else
      eg1 = (i % 5 == 4);
`endif
      cycle(1'b1, a0, 16'h0000, 2'b00, 1'b1, a1, 16'h0000, 2'b00, !eg1, eg1);
      if (eg1) a1 = a1 + 14'd1;
      else     a0 = a0 + 14'd1;
    end
    idle(3);

    // m0 full-word write, then m1 read alone
    cycle(1'b1, 14'h0033, 16'hC0DE, 2'b11, 1'b0, 14'h0000, 16'h0000, 2'b00, 1'b1, 1'b0);
    cycle(1'b0, 14'h0000, 16'h0000, 2'b00, 1'b1, 14'h0048, 16'h0000, 2'b00, 1'b0, 1'b1);
    idle(3);

    // Reset in the cycle after an m0 read grant: access and return are discarded
    push_en = 1'b0;
    cycle(1'b1, 14'h0060, 16'h0000, 2'b00, 1'b0, 14'h0000, 16'h0000, 2'b00, 1'b1, 1'b0);
    push_en = 1'b1;
    @(posedge mclk); #1;
    puc_rst_n = 1'b0;
    drive(1'b0, 14'h0000, 16'h0000, 2'b00, 1'b0, 14'h0000, 16'h0000, 2'b00);
    exp_ptr = 1'b0;
    repeat (2) @(posedge mclk);
    #1 puc_rst_n = 1'b1;
    idle(4);
    check("post_rst_m0_rdata", 32'(m0_rdata), 32'd0);

    // Post-reset grant works again
    cycle(1'b1, 14'h0048, 16'h0000, 2'b00, 1'b0, 14'h0000, 16'h0000, 2'b00, 1'b1, 1'b0);
    idle(3);

    check("per_q_drained", 32'(per_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
